// File: rtl/uart_paddle_decoder_if.sv
// UART byte stream into the decoder and the acknowledge stream back to the transmitter.
// The slave side is the decoder; the master side drives received bytes and tx_ready.
interface uart_paddle_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;

  modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
  modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/uart_paddle_decoder.sv
// Decodes UART command bytes into paddle levels and a start pulse, with per-paddle hold timeout.
// One-cycle registered latency; the ack register is overwritten by newer bytes, so rx is never stalled.
module uart_paddle_decoder #(
  parameter logic [31:0] HOLD_CYCLES = 32'd5_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_paddle_decoder_if.slave        uart,
  output logic                        bbl,
  output logic                        bbr,
  output logic                        tbl,
  output logic                        tbr,
  output logic                        start_ball,
  output logic [7:0]                  err_count
);

  localparam logic [7:0] CMD_BOT_STOP  = 8'h74;
  localparam logic [7:0] CMD_BOT_LEFT  = 8'h62;
  localparam logic [7:0] CMD_BOT_RIGHT = 8'h65;
  localparam logic [7:0] CMD_TOP_STOP  = 8'h6C;
  localparam logic [7:0] CMD_TOP_LEFT  = 8'h6B;
  localparam logic [7:0] CMD_TOP_RIGHT = 8'h6D;
  localparam logic [7:0] CMD_START     = 8'h73;
  localparam logic [7:0] ACK_UNKNOWN   = 8'h3F;

  // Index 0 is the bottom paddle, index 1 the top paddle.
  logic [1:0]       stop_cmd;
  logic [1:0]       left_cmd;
  logic [1:0]       right_cmd;
  logic             start_cmd;
  logic             bad_cmd;
  logic [1:0]       lft;
  logic [1:0]       rgt;
  logic [1:0][31:0] hold_cnt;

  always_comb begin
    stop_cmd  = '0;
    left_cmd  = '0;
    right_cmd = '0;
    start_cmd = 1'b0;
    bad_cmd   = 1'b0;
    if (uart.rx_valid) begin
      case (uart.rx_data)
        CMD_BOT_STOP:  stop_cmd[0]  = 1'b1;
        CMD_BOT_LEFT:  left_cmd[0]  = 1'b1;
        CMD_BOT_RIGHT: right_cmd[0] = 1'b1;
        CMD_TOP_STOP:  stop_cmd[1]  = 1'b1;
        CMD_TOP_LEFT:  left_cmd[1]  = 1'b1;
        CMD_TOP_RIGHT: right_cmd[1] = 1'b1;
        CMD_START:     start_cmd    = 1'b1;
        default:       bad_cmd      = 1'b1;
      endcase
    end
  end

  // A command always beats expiry, so a refresh on the last hold cycle keeps the paddle moving.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lft      <= '0;
      rgt      <= '0;
      hold_cnt <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (stop_cmd[p]) begin
          lft[p]      <= 1'b0;
          rgt[p]      <= 1'b0;
          hold_cnt[p] <= '0;
        end else if (left_cmd[p]) begin
          lft[p]      <= 1'b1;
          rgt[p]      <= 1'b0;
          hold_cnt[p] <= HOLD_CYCLES;
        end else if (right_cmd[p]) begin
          lft[p]      <= 1'b0;
          rgt[p]      <= 1'b1;
          hold_cnt[p] <= HOLD_CYCLES;
        end else if (hold_cnt[p] != 32'd0) begin
          hold_cnt[p] <= hold_cnt[p] - 32'd1;
          if (hold_cnt[p] == 32'd1) begin
            lft[p] <= 1'b0;
            rgt[p] <= 1'b0;
          end
        end
      end
    end
  end

  assign bbl = lft[0];
  assign bbr = rgt[0];
  assign tbl = lft[1];
  assign tbr = rgt[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uart.tx_data  <= 8'h00;
      uart.tx_valid <= 1'b0;
      start_ball    <= 1'b0;
      err_count     <= 8'h00;
    end else begin
      start_ball <= start_cmd;
      if (uart.rx_valid) begin
        uart.tx_valid <= 1'b1;
        uart.tx_data  <= bad_cmd ? ACK_UNKNOWN : uart.rx_data;
      end else if (uart.tx_valid && uart.tx_ready) begin
        uart.tx_valid <= 1'b0;
      end
      if (bad_cmd && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
